// File: rtl/edp_pkg.sv
// edp_pkg: shared definitions for the EBOX datapath (EDP) multiply-step
// sequencer.
//   - AD function codes, ADA/ADB source selects, AR/MQ source selects
//   - the sequencer state enum and the packed control word
// Optional feature macro: EDP_MPY_SIGNED_EN adds the FIXUP state, which
// applies the signed-multiplier correction.
package edp_pkg;

    // AD (adder) function codes.
    localparam logic [5:0] AD_A         = 6'h03;
    localparam logic [5:0] AD_A_PLUS_B  = 6'h06;
    localparam logic [5:0] AD_A_MINUS_B = 6'h09;

    // Adder A/B input sources.
    localparam logic [2:0] ADA_NONE = 3'd0;
    localparam logic [2:0] ADA_AR   = 3'd1;
    localparam logic [1:0] ADB_NONE = 2'd0;
    localparam logic [1:0] ADB_BR   = 2'd1;

    // AR half-word sources. SEL_AD_SHR loads AD[-1:34], i.e. the adder
    // result shifted right one place with the carry entering at the top.
    localparam logic [2:0] SEL_HOLD   = 3'd0;
    localparam logic [2:0] SEL_AD     = 3'd1;
    localparam logic [2:0] SEL_AD_SHR = 3'd2;

    // MQ sources. MQ_SHR loads {AD[35], MQ[0:34]}.
    localparam logic [1:0] MQ_HOLD = 2'd0;
    localparam logic [1:0] MQ_SHR  = 2'd1;

`ifdef EDP_MPY_SIGNED_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STEP, ST_FIXUP, ST_DONE
    } mpy_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STEP, ST_DONE
    } mpy_state_e;
`endif

    // Everything the sequencer drives, decoded from one state.
    typedef struct packed {
        logic [5:0] ad_func;
        logic [2:0] ada_sel;
        logic [1:0] adb_sel;
        logic [2:0] arl_sel;
        logic [2:0] arr_sel;
        logic       ar_load;
        logic       ar_clr;
        logic [1:0] mq_sel;
        logic       ctl_override;
        logic       busy;
        logic       done;
    } ctl_word_t;

endpackage

// File: rtl/edp_mpy_seq_if.sv
// edp_mpy_seq_if: request/status bundle of the multiply sequencer.
//   start  : one-cycle request, sampled only while the sequencer is idle
//   steps  : multiplier bit count presented with start (0..63, clamped)
//   abort  : kills an operation in progress and returns it to idle
//   busy   : high from the cycle after an accepted start through done
//   done   : one-cycle completion pulse (never issued for an aborted op)
// Handshake: there is no ready line. A start is accepted only when busy is
// low and abort is low in the same cycle; a start at any other time is
// dropped, not queued. Completion is the single-cycle done pulse.
interface edp_mpy_seq_if;
    logic       start;
    logic [5:0] steps;
    logic       abort;
    logic       busy;
    logic       done;

    modport master (output start, output steps, output abort,
                    input  busy,  input  done);
    modport slave  (input  start, input  steps, input  abort,
                    output busy,  output done);
endinterface

// File: rtl/edp_mpy_decode.sv
// edp_mpy_decode: combinational map from {state, MQ LSB} to the EDP
// control word. Only the STEP add/no-add choice looks at the MQ bit; every
// other field depends on the state alone.
//   state  : current sequencer state
//   mq_lsb : EDP_MQ[35], the multiplier bit being processed this cycle
//   ctl    : decoded control word
// Optional feature macro: EDP_MPY_SIGNED_EN (FIXUP decode).
module edp_mpy_decode
    import edp_pkg::*;
(
    input  mpy_state_e state,
    input  logic       mq_lsb,
    output ctl_word_t  ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            ST_SETUP: begin
                ctl.ar_clr       = 1'b1;
                ctl.ctl_override = 1'b1;
                ctl.busy         = 1'b1;
            end
            ST_STEP: begin
                ctl.ada_sel      = ADA_AR;
                ctl.adb_sel      = ADB_BR;
                ctl.ad_func      = mq_lsb ? AD_A_PLUS_B : AD_A;
                ctl.arl_sel      = SEL_AD_SHR;
                ctl.arr_sel      = SEL_AD_SHR;
                ctl.mq_sel       = MQ_SHR;
                ctl.ar_load      = 1'b1;
                ctl.ctl_override = 1'b1;
                ctl.busy         = 1'b1;
            end
`ifdef EDP_MPY_SIGNED_EN
            ST_FIXUP: begin
                // AR <- AR - BR corrects for the multiplier's sign weight.
                ctl.ada_sel      = ADA_AR;
                ctl.adb_sel      = ADB_BR;
                ctl.ad_func      = AD_A_MINUS_B;
                ctl.arl_sel      = SEL_AD;
                ctl.arr_sel      = SEL_AD;
                ctl.mq_sel       = MQ_HOLD;
                ctl.ar_load      = 1'b1;
                ctl.ctl_override = 1'b1;
                ctl.busy         = 1'b1;
            end
`endif
            ST_DONE: begin
                ctl.busy = 1'b1;
                ctl.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/edp_mpy_seq.sv
// edp_mpy_seq: shift-and-add multiply sequencer for the EBOX datapath.
// Multiplies BR by MQ one multiplier bit per cycle, leaving the 72-bit
// product in AR (high) and MQ (low). While it owns the datapath
// (ctlOverride) its control word replaces the CRAM-derived controls.
//   eboxClk, eboxReset : clock, synchronous active-high reset
//   req                : start/steps/abort in, busy/done out
//   EDP_MQ             : MQ register [0:35]; bit 35 = add/no-add, bit 0 = sign
//   adFunc..mqSel      : EDP control word
//   ctlOverride        : sequencer owns the EDP controls
//   dbg_state          : current FSM state
// Optional feature macro: EDP_MPY_SIGNED_EN (signed-multiplier FIXUP).
module edp_mpy_seq
    import edp_pkg::*;
#(
    parameter int MAX_STEPS = 36
) (
    input  logic                eboxClk,
    input  logic                eboxReset,
    edp_mpy_seq_if.slave        req,
    input  logic [0:35]         EDP_MQ,
    output logic [5:0]          adFunc,
    output logic [2:0]          adaSel,
    output logic [1:0]          adbSel,
    output logic [2:0]          arlSel,
    output logic [2:0]          arrSel,
    output logic                arLoad,
    output logic                arClr,
    output logic [1:0]          mqSel,
    output logic                ctlOverride,
    output mpy_state_e          dbg_state
);

    localparam logic [5:0] MAX_STEPS6 = 6'(MAX_STEPS);

    mpy_state_e state, state_n, fin_state;
    logic [5:0] cnt;
    logic [5:0] steps_clamped;
    logic       start_take;
    ctl_word_t  ctl;

    // Only the sign bit and the LSB of MQ matter to the sequencer.
    logic unused_mq;
    assign unused_mq = ^EDP_MQ[0:34];

    assign steps_clamped = (req.steps > MAX_STEPS6) ? MAX_STEPS6 : req.steps;
    assign start_take    = (state == ST_IDLE) && req.start && !req.abort;

`ifdef EDP_MPY_SIGNED_EN
    logic mq_sign;
    always_comb fin_state = mq_sign ? ST_FIXUP : ST_DONE;
`else
    always_comb fin_state = ST_DONE;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (req.start) state_n = ST_SETUP;
            ST_SETUP: state_n = (cnt != 6'd0) ? ST_STEP : fin_state;
            ST_STEP:  state_n = (cnt > 6'd1) ? ST_STEP : fin_state;
`ifdef EDP_MPY_SIGNED_EN
            ST_FIXUP: state_n = ST_DONE;
`endif
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (req.abort) state_n = ST_IDLE;
    end

    // Count and sign are captured on the edge that accepts start, so they
    // are already valid while SETUP decides between STEP and the tail.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_n;
            if (start_take)
                cnt <= steps_clamped;
            else if (state == ST_STEP && !req.abort)
                cnt <= cnt - 6'd1;
        end
    end

`ifdef EDP_MPY_SIGNED_EN
    always_ff @(posedge eboxClk) begin
        if (eboxReset)
            mq_sign <= 1'b0;
        else if (start_take)
            mq_sign <= EDP_MQ[0];
    end
`endif

    edp_mpy_decode u_decode (
        .state  (state),
        .mq_lsb (EDP_MQ[35]),
        .ctl    (ctl)
    );

    assign adFunc      = ctl.ad_func;
    assign adaSel      = ctl.ada_sel;
    assign adbSel      = ctl.adb_sel;
    assign arlSel      = ctl.arl_sel;
    assign arrSel      = ctl.arr_sel;
    assign arLoad      = ctl.ar_load;
    assign arClr       = ctl.ar_clr;
    assign mqSel       = ctl.mq_sel;
    assign ctlOverride = ctl.ctl_override;
    assign req.busy    = ctl.busy;
    assign req.done    = ctl.done;
    assign dbg_state   = state;

endmodule

// File: tb/tb_edp_mpy_seq.sv
// tb_edp_mpy_seq: bench for edp_mpy_seq. A small EDP datapath model (AR,
// BR, MQ and the adder) obeys the control word; results are compared with
// plain-arithmetic products, fixed vectors, and hand-built abort/reset runs.
module tb_edp_mpy_seq;
    import edp_pkg::*;

    // ---------------- clock / reset ----------------
    logic eboxClk = 1'b0;
    logic eboxReset;
    always #5 eboxClk = ~eboxClk;

    edp_mpy_seq_if req ();

    logic [35:0] ar, mq, br;
    logic [0:35] edp_mq;
    logic [5:0]  adFunc;
    logic [2:0]  adaSel, arlSel, arrSel;
    logic [1:0]  adbSel, mqSel;
    logic        arLoad, arClr, ctlOverride;
    mpy_state_e  dbg_state;

    assign edp_mq = mq;  // MSB-to-MSB: edp_mq[35] is the LSB mq[0]

    edp_mpy_seq #(.MAX_STEPS(36)) dut (
        .eboxClk     (eboxClk),
        .eboxReset   (eboxReset),
        .req         (req),
        .EDP_MQ      (edp_mq),
        .adFunc      (adFunc),
        .adaSel      (adaSel),
        .adbSel      (adbSel),
        .arlSel      (arlSel),
        .arrSel      (arrSel),
        .arLoad      (arLoad),
        .arClr       (arClr),
        .mqSel       (mqSel),
        .ctlOverride (ctlOverride),
        .dbg_state   (dbg_state)
    );

    // ---------------- EDP datapath model ----------------
    logic        pre_ld;
    logic [35:0] pre_ar, pre_mq, pre_br;
    logic [36:0] ad_a, ad_b, ad;

    always_comb begin
        ad_a = (adaSel == ADA_AR) ? {1'b0, ar} : 37'd0;
        ad_b = (adbSel == ADB_BR) ? {1'b0, br} : 37'd0;
        case (adFunc)
            AD_A:         ad = ad_a;
            AD_A_PLUS_B:  ad = ad_a + ad_b;
            AD_A_MINUS_B: ad = ad_a - ad_b;
            default:      ad = 37'd0;
        endcase
    end

    always @(posedge eboxClk) begin
        if (pre_ld) begin
            ar <= pre_ar;
            mq <= pre_mq;
            br <= pre_br;
        end else begin
            if (arClr) ar <= 36'd0;
            else if (arLoad) begin
                ar[35:18] <= (arlSel == SEL_AD_SHR) ? ad[36:19] :
                             (arlSel == SEL_AD)     ? ad[35:18] : ar[35:18];
                ar[17:0]  <= (arrSel == SEL_AD_SHR) ? ad[18:1] :
                             (arrSel == SEL_AD)     ? ad[17:0]  : ar[17:0];
            end
            if (mqSel == MQ_SHR) mq <= {ad[0], mq[35:1]};
        end
    end

    int done_cnt = 0;
    always @(negedge eboxClk) if (req.done === 1'b1) done_cnt++;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [71:0] exp_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: k steps of shift-and-add leave the low k multiplier bits'
    // product aligned above the not-yet-consumed multiplier bits.
    function automatic logic [71:0] ref_prod(input logic [35:0] b, input logic [35:0] m, input int k);
        logic [71:0] b72, m72, lo, p;
        b72 = {36'd0, b};
        m72 = {36'd0, m};
        lo  = (k == 0) ? 72'd0 : (m72 & ((72'd1 << k) - 72'd1));
        p   = ((b72 * lo) << (36 - k)) + (m72 >> k);
`ifdef EDP_MPY_SIGNED_EN
        if (m[35]) p = p - (b72 << 36);
`endif
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [35:0] b, input logic [35:0] m);
        @(negedge eboxClk);
        pre_ld = 1'b1;
        pre_br = b;
        pre_mq = m;
        pre_ar = 36'({$urandom(), $urandom()});
        @(negedge eboxClk);
        pre_ld = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge of the done cycle
    // (cycle 1 = SETUP) or -1 if done never arrives.
    task automatic run_op(input logic [35:0] b, input logic [35:0] m, input logic [5:0] s,
                          input int repulse_at, output int done_cyc);
        int cyc;
        preload(b, m);
        req.start = 1'b1;
        req.steps = s;
        @(negedge eboxClk);
        req.start = 1'b0;
        cyc = 1;
        check("setup_ctl", {67'd0, arClr, ctlOverride, req.busy, arLoad, req.done}, 72'b11100);
        while (req.done !== 1'b1 && cyc < 200) begin
            req.start = (cyc == repulse_at);
            if (cyc == repulse_at) req.steps = 6'd3;
            @(negedge eboxClk);
            cyc++;
        end
        req.start = 1'b0;
        done_cyc = (req.done === 1'b1) ? cyc : -1;
    endtask

    task automatic finish_op(input string name, input int done_before);
        @(negedge eboxClk);
        check({name, "_idle"}, {70'd0, req.busy, ctlOverride}, 72'd0);
        check({name, "_ndone"}, 72'(done_cnt - done_before), 72'd1);
    endtask

    typedef struct {
        logic [35:0] br;
        logic [35:0] mq;
        logic [5:0]  steps;
        int          repulse;
        logic [35:0] exp_ar;
        logic [35:0] exp_mq;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int dc, d0, k, s;
        logic [35:0] rb, rm;
        logic [71:0] p;

        vecs[0] = '{36'd5, 36'd3, 6'd36, 0,  36'd0, 36'h00000000F, 38};
        vecs[1] = '{36'd5, 36'd3, 6'd0,  0,  36'd0, 36'd3, 2};
        vecs[2] = '{36'd7, 36'd2, 6'd36, 0,  36'd0, 36'h00000000E, 38};
        vecs[3] = '{36'd5, 36'd3, 6'd36, 10, 36'd0, 36'h00000000F, 38};
        vecs[4] = '{36'd3, 36'd5, 6'd50, 0,  36'd0, 36'h00000000F, 38};
        vecs[5] = '{36'd5, 36'd3, 6'd1,  0,  36'd2, 36'h800000001, 3};
`ifdef EDP_MPY_SIGNED_EN
        vecs[6] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 6'd36, 0, 36'hFFFFFFFFF, 36'h000000001, 39};
        vecs[7] = '{36'd5, 36'hFFFFFFFFF, 6'd36, 0, 36'hFFFFFFFFF, 36'hFFFFFFFFB, 39};
`else
        vecs[6] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 6'd36, 0, 36'hFFFFFFFFE, 36'h000000001, 38};
        vecs[7] = '{36'd5, 36'hFFFFFFFFF, 6'd36, 0, 36'd4, 36'hFFFFFFFFB, 38};
`endif

        eboxReset = 1'b1;
        req.start = 1'b0;
        req.steps = 6'd0;
        req.abort = 1'b0;
        pre_ld    = 1'b0;
        pre_ar    = 36'd0;
        pre_mq    = 36'd0;
        pre_br    = 36'd0;
        repeat (3) @(negedge eboxClk);
        check("rst_outputs", {45'd0, adFunc, adaSel, adbSel, arlSel, arrSel, arLoad, arClr, mqSel, ctlOverride, req.busy, req.done}, 72'd0);
        check("rst_state", 72'(dbg_state), 72'(ST_IDLE));
        eboxReset = 1'b0;

        // Fixed vectors.
        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            run_op(vecs[i].br, vecs[i].mq, vecs[i].steps, vecs[i].repulse, dc);
            check($sformatf("vec%0d_cyc", i), 72'(dc), 72'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_ar", i), 72'(ar), 72'(vecs[i].exp_ar));
            check($sformatf("vec%0d_mq", i), 72'(mq), 72'(vecs[i].exp_mq));
            finish_op($sformatf("vec%0d", i), d0);
        end

        // Abort at cycle 15: everything drops in cycle 16, no done ever.
        preload(36'd5, 36'd3);
        d0 = done_cnt;
        req.start = 1'b1;
        req.steps = 6'd36;
        @(negedge eboxClk);
        req.start = 1'b0;
        repeat (14) @(negedge eboxClk);
        req.abort = 1'b1;
        @(negedge eboxClk);
        req.abort = 1'b0;
        check("abort_outputs", {45'd0, adFunc, adaSel, adbSel, arlSel, arrSel, arLoad, arClr, mqSel, ctlOverride, req.busy, req.done}, 72'd0);
        repeat (45) @(negedge eboxClk);
        check("abort_nodone", 72'(done_cnt - d0), 72'd0);

        // Abort and start together while idle: stay idle.
        req.start = 1'b1;
        req.abort = 1'b1;
        req.steps = 6'd4;
        @(negedge eboxClk);
        req.start = 1'b0;
        req.abort = 1'b0;
        check("abort_start_idle", {70'd0, req.busy, ctlOverride}, 72'd0);
        repeat (10) @(negedge eboxClk);
        check("abort_start_nodone", 72'(done_cnt - d0), 72'd0);

        // Reset at cycle 20 of a negative-multiplier run, then a clean run.
        preload(36'd9, 36'h800000003);
        d0 = done_cnt;
        req.start = 1'b1;
        req.steps = 6'd36;
        @(negedge eboxClk);
        req.start = 1'b0;
        repeat (19) @(negedge eboxClk);
        eboxReset = 1'b1;
        @(negedge eboxClk);
        eboxReset = 1'b0;
        check("reset_mid_idle", {67'd0, req.busy, ctlOverride, arLoad, arClr, req.done}, 72'd0);
        check("reset_mid_state", 72'(dbg_state), 72'(ST_IDLE));
        repeat (2) @(negedge eboxClk);
        check("reset_mid_nodone", 72'(done_cnt - d0), 72'd0);
        run_op(36'd7, 36'd2, 6'd36, 0, dc);
        check("post_reset_cyc", 72'(dc), 72'd38);
        check("post_reset_ar", 72'(ar), 72'd0);
        check("post_reset_mq", 72'(mq), 72'h00000000E);
        finish_op("post_reset", d0);

        // Random operands and step counts against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            rb = 36'({$urandom(), $urandom()});
            rm = 36'({$urandom(), $urandom()});
            s  = int'($urandom_range(0, 63));
            k  = (s > 36) ? 36 : s;
            exp_q.push_back(ref_prod(rb, rm, k));
            d0 = done_cnt;
            run_op(rb, rm, 6'(s), 0, dc);
            p = exp_q.pop_front();
            k = k + 2;
`ifdef EDP_MPY_SIGNED_EN
            if (rm[35]) k = k + 1;
`endif
            check($sformatf("rnd%0d_cyc", i), 72'(dc), 72'(k));
            check($sformatf("rnd%0d_prod", i), {ar, mq}, p);
            finish_op($sformatf("rnd%0d", i), d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
